// File: rtl/mem_1rw_byte_mask_rmw_initiator.sv
// Client front end for a single-port SRAM without a write mask: full-mask writes pass
// straight through, partial-mask writes become read + merged write, reads return on valid/yumi.
module mem_1rw_byte_mask_rmw_initiator #(
    parameter int width_p = 64,
    parameter int els_p = 512,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int write_mask_width_lp = width_p >> 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [width_p-1:0]             data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic                           v_o,
    output logic [width_p-1:0]             data_o,
    input  logic                           yumi_i,
    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [addr_width_lp-1:0]       mem_addr_o,
    output logic [width_p-1:0]             mem_data_o,
    input  logic [width_p-1:0]             mem_data_i
);

    typedef enum logic [1:0] {IDLE, MERGE, RESP} state_e;

    state_e                         state_r;
    logic [addr_width_lp-1:0]       addr_p1;
    logic [width_p-1:0]             data_p1;
    logic [write_mask_width_lp-1:0] mask_p1;

    logic accept;
    logic mask_full;
    logic mask_none;
    logic partial_wr;

    function automatic logic [width_p-1:0] merge_bytes(
        input logic [width_p-1:0]             new_data,
        input logic [width_p-1:0]             old_data,
        input logic [write_mask_width_lp-1:0] mask
    );
        logic [width_p-1:0] merged;
        merged = old_data;
        for (int i = 0; i < write_mask_width_lp; i++) begin
            if (mask[i]) merged[8*i +: 8] = new_data[8*i +: 8];
        end
        return merged;
    endfunction

    assign ready_o    = ~reset_i & ((state_r == IDLE) | ((state_r == RESP) & yumi_i));
    assign accept     = v_i & ready_o;
    assign mask_full  = &write_mask_i;
    assign mask_none  = ~|write_mask_i;
    assign partial_wr = w_i & ~mask_full & ~mask_none;

    // The memory holds its last read word, so the response is served straight from it.
    assign v_o    = ~reset_i & (state_r == RESP);
    assign data_o = mem_data_i;

    always_comb begin
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = addr_i;
        mem_data_o = data_i;
        if (!reset_i) begin
            if (state_r == MERGE) begin
                mem_v_o    = 1'b1;
                mem_w_o    = 1'b1;
                mem_addr_o = addr_p1;
                mem_data_o = merge_bytes(data_p1, mem_data_i, mask_p1);
            end else if (accept) begin
                if (!w_i) begin
                    mem_v_o = 1'b1;
                end else if (mask_full) begin
                    mem_v_o = 1'b1;
                    mem_w_o = 1'b1;
                end else if (!mask_none) begin
                    mem_v_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                MERGE: state_r <= IDLE;
                IDLE, RESP: begin
                    if (accept) begin
                        if (!w_i)            state_r <= RESP;
                        else if (partial_wr) state_r <= MERGE;
                        else                 state_r <= IDLE;
                    end else if (state_r == RESP && yumi_i) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Partial-write operands held for the merge cycle
    always_ff @(posedge clk_i) begin
        if (accept && partial_wr) begin
            addr_p1 <= addr_i;
            data_p1 <= data_i;
            mask_p1 <= write_mask_i;
        end
    end

endmodule

// File: tb/tb_mem_1rw_byte_mask_rmw_initiator.sv
// Bench for mem_1rw_byte_mask_rmw_initiator: SRAM model on the memory side, word-level
// reference memory with an expected-response queue, and a monitor on the read port.
module tb_mem_1rw_byte_mask_rmw_initiator;

    localparam int W  = 64;
    localparam int N  = 512;
    localparam int AW = 9;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i, ready_o, w_i;
    logic [AW-1:0] addr_i;
    logic [W-1:0]  data_i;
    logic [MW-1:0] write_mask_i;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic          mem_v_o, mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_data_o, mem_data_i;

    always #5 clk = ~clk;

    mem_1rw_byte_mask_rmw_initiator #(.width_p(W), .els_p(N)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
        .addr_i(addr_i), .data_i(data_i), .write_mask_i(write_mask_i),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    function automatic logic [W-1:0] pat(input int i);
        return 64'(i) * 64'h9E37_79B9_7F4A_7C15 + 64'h0F0F;
    endfunction

    // SRAM model: synchronous read, read data held until the next read
    logic [W-1:0] sram [N];
    logic [W-1:0] sram_rd;
    logic         bd_fill;
    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < N; i++) sram[i] <= pat(i);
        end else if (mem_v_o) begin
            if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
            else         sram_rd <= sram[mem_addr_o];
        end
    end
    assign mem_data_i = sram_rd;

    // Reference model: word array updated at request acceptance, expected read data queued
    logic [W-1:0] ref_mem [N];
    logic [W-1:0] exp_q [$];
    int n_cmp = 0, n_bad = 0, resp_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] byte_merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                                input logic [MW-1:0] m);
        logic [W-1:0] r;
        for (int b = 0; b < MW; b++) r[8*b +: 8] = m[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    task automatic model_accept(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                                input logic [MW-1:0] m);
        if (!w) exp_q.push_back(ref_mem[a]);
        else    ref_mem[a] = byte_merge(ref_mem[a], d, m);
    endtask

    // yumi generator: only ever asserted while a response is shown
    logic yumi_en, yumi_rand;
    always @(posedge clk) begin
        #1;
        yumi_i = v_o && yumi_en && (!yumi_rand || ($urandom_range(1) == 1));
    end

    // Monitor: compares every presented response against the queue head
    always @(negedge clk) begin
        if (reset_i) begin
            chk("rst_v_o", 64'(v_o), 64'd0);
            chk("rst_ready_o", 64'(ready_o), 64'd0);
        end else begin
            if (yumi_i && !v_o) begin
                n_cmp++; n_bad++;
                $display("FAIL yumi_without_v_o: got yumi=1, expected v_o=1");
            end
            if (!mem_v_o && mem_w_o) begin
                n_cmp++; n_bad++;
                $display("FAIL mem_w_without_v: got mem_w_o=1, expected 0");
            end
            if (v_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL resp_unexpected: got data %h, expected no response", data_o);
                end else begin
                    chk("resp_data", data_o, exp_q[0]);
                    if (yumi_i) begin
                        void'(exp_q.pop_front());
                        resp_cnt++;
                    end
                end
            end
        end
    end

    logic          snap_v, snap_w;
    logic [AW-1:0] snap_addr;
    logic [W-1:0]  snap_data;
    int            snap_wait;

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [MW-1:0] m, input logic upd);
        v_i = 1'b1; w_i = w; addr_i = a; data_i = d; write_mask_i = m;
        snap_wait = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            snap_wait++;
            if (snap_wait > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: got ready_o=0 for 200 cycles, expected 1");
                break;
            end
            @(posedge clk); #1;
        end
        snap_v = mem_v_o; snap_w = mem_w_o; snap_addr = mem_addr_o; snap_data = mem_data_o;
        if (ready_o && upd) model_accept(w, a, d, m);
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] m;
        int c0;
        reset_i = 1'b1; bd_fill = 1'b1; yumi_en = 1'b0; yumi_rand = 1'b0;
        v_i = 1'b1; w_i = 1'b0; addr_i = '0; data_i = '0; write_mask_i = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = pat(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_v_o", 64'(mem_v_o), 64'd0);
        @(posedge clk); #1;
        reset_i = 1'b0; bd_fill = 1'b0; v_i = 1'b0;
        @(negedge clk);
        chk("idle_ready_o", 64'(ready_o), 64'd1);
        yumi_en = 1'b1;
        @(posedge clk); #1;

        // Read after reset
        issue(1'b1, 9'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        issue(1'b0, 9'd5, '0, '0, 1'b1);
        chk("rd5_mem_v", 64'(snap_v), 64'd1);
        chk("rd5_mem_w", 64'(snap_w), 64'd0);
        chk("rd5_mem_addr", 64'(snap_addr), 64'd5);
        @(negedge clk);
        chk("rd5_v_o", 64'(v_o), 64'd1);
        chk("rd5_data", data_o, 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;

        // Full-mask write
        issue(1'b1, 9'd7, 64'hFFFF_0000_FFFF_0000, 8'hFF, 1'b1);
        chk("fw_mem_v", 64'(snap_v), 64'd1);
        chk("fw_mem_w", 64'(snap_w), 64'd1);
        chk("fw_mem_addr", 64'(snap_addr), 64'd7);
        chk("fw_mem_data", snap_data, 64'hFFFF_0000_FFFF_0000);
        @(negedge clk);
        chk("fw_no_2nd_access", 64'(mem_v_o), 64'd0);
        @(posedge clk); #1;
        issue(1'b0, 9'd7, '0, '0, 1'b1);
        @(negedge clk);
        chk("fw_readback", data_o, 64'hFFFF_0000_FFFF_0000);
        @(posedge clk); #1;

        // Partial-mask read-modify-write
        issue(1'b1, 9'd3, 64'h1111_1111_1111_1111, 8'hFF, 1'b1);
        issue(1'b1, 9'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b1);
        chk("rmw_rd_v", 64'(snap_v), 64'd1);
        chk("rmw_rd_w", 64'(snap_w), 64'd0);
        chk("rmw_rd_addr", 64'(snap_addr), 64'd3);
        @(negedge clk);
        chk("rmw_wr_v", 64'(mem_v_o), 64'd1);
        chk("rmw_wr_w", 64'(mem_w_o), 64'd1);
        chk("rmw_wr_addr", 64'(mem_addr_o), 64'd3);
        chk("rmw_wr_data", mem_data_o, 64'h1111_1111_AAAA_AAAA);
        chk("rmw_ready_o", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        issue(1'b0, 9'd3, '0, '0, 1'b1);

        // Backpressure, then yumi with a new read in the same cycle
        @(negedge clk); yumi_en = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 9'd2, '0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_v_o", 64'(v_o), 64'd1);
            chk("bp_data", data_o, pat(2));
            chk("bp_mem_v", 64'(mem_v_o), 64'd0);
            chk("bp_ready_o", 64'(ready_o), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk); yumi_en = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 9'd9, '0, '0, 1'b1);
        chk("bp_same_cycle_accept", 64'(snap_wait), 64'd0);
        @(negedge clk);
        chk("bp_next_word", data_o, pat(9));
        @(posedge clk); #1;

        // Zero-mask write, then streaming reads
        issue(1'b1, 9'd4, {$urandom, $urandom}, 8'h00, 1'b1);
        chk("zm_no_access", 64'(snap_v), 64'd0);
        c0 = resp_cnt;
        for (int k = 0; k < 8; k++) begin
            v_i = 1'b1; w_i = 1'b0; addr_i = (k == 0) ? 9'd4 : AW'(9 + k);
            @(negedge clk);
            chk("st_ready_o", 64'(ready_o), 64'd1);
            if (k > 0) chk("st_v_o", 64'(v_o), 64'd1);
            if (ready_o) model_accept(1'b0, addr_i, '0, '0);
            @(posedge clk); #1;
        end
        v_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("st_resp_count", 64'(resp_cnt - c0), 64'd8);

        // Reset during the merge cycle
        issue(1'b1, 9'd6, {$urandom, $urandom}, 8'h3C, 1'b0);
        reset_i = 1'b1;
        @(negedge clk);
        chk("rm_mem_v", 64'(mem_v_o), 64'd0);
        chk("rm_ready_o", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("rm_idle_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        issue(1'b0, 9'd6, '0, '0, 1'b1);
        @(negedge clk);
        chk("rm_word_kept", data_o, pat(6));
        @(posedge clk); #1;

        // Randomized traffic with random yumi
        @(negedge clk); yumi_rand = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(3))
                0: m = 8'hFF;
                1: m = 8'h00;
                default: m = MW'($urandom);
            endcase
            issue(1'($urandom_range(1)), AW'($urandom_range(15)), {$urandom, $urandom}, m, 1'b1);
        end

        @(negedge clk); yumi_rand = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
